fetch_entry_queue: RTL

Elastic buffer between the frontend and the decode stage. It accepts `ariane_pkg::fetch_entry_t` entries from the frontend and presents them in order to decode through a valid/ready handshake. It decouples frontend stalls from decode back-pressure, drops its whole contents on a pipeline flush, and stops accepting entries after an excepting one until the next flush.

---
 rtl/ariane_pkg.sv | 20 ++
 rtl/fetch_entry_queue.sv | 74 +++++++
 2 files changed

// File: rtl/ariane_pkg.sv
// Shared frontend/decode types: the fetch entry handed from the frontend to decode
// and the depth of the elastic fetch queue between them.
package ariane_pkg;

  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [5:0]  cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
    logic        is_compressed;
    exception_t  ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_queue.sv
// Elastic in-order buffer between the frontend and decode. Drops everything on flush
// and refuses new entries after an excepting one until the next flush.
module fetch_entry_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fetch_entry_t             fetch_entry_i,
  input  logic                     fetch_entry_valid_i,
  output logic                     fetch_entry_ready_o,
  output fetch_entry_t             fetch_entry_o,
  output logic                     fetch_entry_valid_o,
  input  logic                     fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]   usage_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          ex_block_q;
  logic          push, pop;

  // Ready and valid look only at registered state and flush, so decode's ready may
  // depend combinationally on our valid without forming a loop.
  assign fetch_entry_ready_o = (count_q != FULL) && !ex_block_q && !flush_i;
  assign fetch_entry_valid_o = (count_q != '0) && !flush_i;
  assign fetch_entry_o       = mem_q[rd_ptr_q];
  assign usage_o             = count_q;

  assign push = fetch_entry_valid_i && fetch_entry_ready_o;
  assign pop  = fetch_entry_valid_o && fetch_entry_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ex_block_q <= 1'b0;
    end else if (flush_i) begin
      // Storage is left as-is; with count at zero it is never read as valid.
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ex_block_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= fetch_entry_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
        if (fetch_entry_i.ex.valid) ex_block_q <= 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (count_q != FULL));

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop |-> (count_q != '0));

  a_stable_stall : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fetch_entry_valid_o && !fetch_entry_ready_i) |=> $stable(fetch_entry_o));

endmodule
